// File: rtl/icache_pkg.sv
// Shared types and default geometry for the two-way instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ic_state_t;

  localparam int unsigned DEF_SETS       = 64;
  localparam int unsigned DEF_LINE_BYTES = 16;
  localparam int unsigned DEF_VA_W       = 32;
  localparam int unsigned DATA_W         = 64;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM; reads return the contents before a same-cycle write.
module sp_ram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with beat-wise line fill, per-set LRU
// and a set-by-set invalidate sweep that also runs out of reset.
module icache_2way
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned VA_W       = DEF_VA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ff,
  input  logic [VA_W-1:0]   fetch_addr_ff,
  input  logic              write_ff,
  input  logic [VA_W-1:0]   write_addr_ff,
  input  logic [DATA_W-1:0] write_data_ff,
  input  logic              inval_ff,
  output logic [VA_W-1:0]   ic_addr_if,
  output logic [DATA_W-1:0] ic_data_if,
  output logic              ic_hit_if,
  output logic              ic_miss_if,
  output logic              busy
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WORDS  = LINE_BYTES / 8;
  localparam int unsigned WORD_W = OFF_W - 3;
  localparam int unsigned TAG_W  = VA_W - IDX_W - OFF_W;
  localparam int unsigned DA_W   = IDX_W + WORD_W;

  ic_state_t        state_q;
  logic [IDX_W-1:0] flush_cnt_q;
  logic [SETS-1:0]  lru_q;
  logic             victim_q;
  logic             fetch_q;
  logic             acc_q;

  logic [IDX_W-1:0]  f_idx, w_idx, r_idx;
  logic [WORD_W-1:0] f_word, w_word;
  logic [TAG_W-1:0]  w_tag, r_tag;
  logic              idle, fetch_acc, write_acc, first_beat, last_beat, fill_way, hit;
  logic [1:0]        hit_way;
  logic [IDX_W-1:0]  tag_addr;
  logic [TAG_W:0]    tag_wdata;
  logic [DA_W-1:0]   data_addr;
  logic [TAG_W:0]    tag_rd  [2];
  logic [DATA_W-1:0] data_rd [2];
  logic              unused_bits;

  assign f_idx  = fetch_addr_ff[OFF_W +: IDX_W];
  assign f_word = fetch_addr_ff[3 +: WORD_W];
  assign w_idx  = write_addr_ff[OFF_W +: IDX_W];
  assign w_word = write_addr_ff[3 +: WORD_W];
  assign w_tag  = write_addr_ff[VA_W-1 -: TAG_W];
  assign r_idx  = ic_addr_if[OFF_W +: IDX_W];
  assign r_tag  = ic_addr_if[VA_W-1 -: TAG_W];

  assign idle       = (state_q == IDLE);
  assign fetch_acc  = fetch_ff && !write_ff && !inval_ff && idle;
  assign write_acc  = write_ff && !inval_ff && idle;
  assign first_beat = write_acc && (w_word == '0);
  assign last_beat  = write_acc && (w_word == WORD_W'(WORDS - 1));
  // The victim is chosen on the word-0 beat and held for the rest of the line.
  assign fill_way   = first_beat ? lru_q[w_idx] : victim_q;

  // Port priority: flush sweep, then fill beat, then fetch.
  assign tag_addr  = !idle ? flush_cnt_q : (write_acc ? w_idx : f_idx);
  assign tag_wdata = !idle ? '0 : {last_beat, w_tag};
  assign data_addr = write_acc ? {w_idx, w_word} : {f_idx, f_word};

  for (genvar w = 0; w < 2; w++) begin : g_way
    sp_ram #(
      .WIDTH (TAG_W + 1),
      .DEPTH (SETS)
    ) u_tag (
      .clk   (clk),
      .we    (!idle || ((first_beat || last_beat) && (fill_way == 1'(w)))),
      .addr  (tag_addr),
      .wdata (tag_wdata),
      .rdata (tag_rd[w])
    );

    sp_ram #(
      .WIDTH (DATA_W),
      .DEPTH (SETS * WORDS)
    ) u_data (
      .clk   (clk),
      .we    (write_acc && (fill_way == 1'(w))),
      .addr  (data_addr),
      .wdata (write_data_ff),
      .rdata (data_rd[w])
    );

    assign hit_way[w] = tag_rd[w][TAG_W] && (tag_rd[w][TAG_W-1:0] == r_tag);
  end

  assign hit        = acc_q && (|hit_way);
  assign ic_hit_if  = fetch_q && hit;
  assign ic_miss_if = fetch_q && !hit;
  assign ic_data_if = hit_way[1] ? data_rd[1] : data_rd[0];
  assign busy       = (state_q == FLUSH);

  assign unused_bits = ^{fetch_addr_ff[2:0], write_addr_ff[2:0], ic_addr_if[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      fetch_q     <= 1'b0;
      acc_q       <= 1'b0;
      ic_addr_if  <= '0;
    end else begin
      fetch_q <= fetch_ff;
      acc_q   <= fetch_acc;
      if (fetch_ff) ic_addr_if <= fetch_addr_ff;
      if (ic_hit_if) lru_q[r_idx] <= ~hit_way[1];
      if (first_beat) victim_q <= lru_q[w_idx];
      // Later assignment: a completing fill overrides a hit update to the same set.
      if (last_beat) lru_q[w_idx] <= ~fill_way;
      case (state_q)
        IDLE: begin
          if (inval_ff) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == IDX_W'(SETS - 1)) begin
            state_q <= IDLE;
            lru_q   <= '0;
          end
        end
        default: state_q <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Randomised scoreboard bench for icache_2way against a line-level cache model.
module tb_icache_2way;

  localparam int SETS  = 64;
  localparam int LB    = 16;
  localparam int WORDS = LB / 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ff = 1'b0, write_ff = 1'b0, inval_ff = 1'b0;
  logic [31:0] fetch_addr_ff = '0, write_addr_ff = '0;
  logic [63:0] write_data_ff = '0;
  logic [31:0] ic_addr_if;
  logic [63:0] ic_data_if;
  logic        ic_hit_if, ic_miss_if, busy;

  icache_2way #(
    .SETS       (64),
    .LINE_BYTES (16),
    .VA_W       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_ff      (fetch_ff),
    .fetch_addr_ff (fetch_addr_ff),
    .write_ff      (write_ff),
    .write_addr_ff (write_addr_ff),
    .write_data_ff (write_data_ff),
    .inval_ff      (inval_ff),
    .ic_addr_if    (ic_addr_if),
    .ic_data_if    (ic_data_if),
    .ic_hit_if     (ic_hit_if),
    .ic_miss_if    (ic_miss_if),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each line is {valid, tag, words}; lru holds the next victim way.
  bit          m_val  [2][SETS];
  int unsigned m_tag  [2][SETS];
  logic [63:0] m_data [2][SETS][WORDS];
  bit          m_lru  [SETS];
  bit          m_vic;
  int          m_busy_left;
  bit          pend_valid;
  int          pend_set;
  bit          pend_way;

  typedef struct {
    logic        hit;
    logic [63:0] data;
    logic [31:0] addr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LB) % SETS);
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'((a / 8) % WORDS);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LB * SETS);
  endfunction

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < SETS; s++) m_val[w][s] = 1'b0;
    for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
    m_busy_left = SETS;
  endtask

  task automatic model_step();
    bit   idle, acc, wacc, new_pend, new_way;
    int   fs, ws, wd;
    exp_t e;
    idle     = (m_busy_left == 0);
    acc      = fetch_ff && !write_ff && !inval_ff && idle;
    wacc     = write_ff && !inval_ff && idle;
    new_pend = 1'b0;
    new_way  = 1'b0;
    fs       = set_of(fetch_addr_ff);
    if (fetch_ff) begin
      e.addr = fetch_addr_ff;
      e.cyc  = cyc;
      e.hit  = 1'b0;
      e.data = '0;
      if (acc)
        for (int w = 0; w < 2; w++)
          if (m_val[w][fs] && m_tag[w][fs] == tag_of(fetch_addr_ff)) begin
            e.hit    = 1'b1;
            e.data   = m_data[w][fs][word_of(fetch_addr_ff)];
            new_pend = 1'b1;
            new_way  = w[0];
          end
      exp_q.push_back(e);
    end
    ws = set_of(write_addr_ff);
    wd = word_of(write_addr_ff);
    if (wacc && wd == 0) m_vic = m_lru[ws];
    if (pend_valid) m_lru[pend_set] = !pend_way;
    if (wacc) begin
      if (wd == 0) m_val[m_vic][ws] = 1'b0;
      m_data[m_vic][ws][wd] = write_data_ff;
      if (wd == WORDS - 1) begin
        m_val[m_vic][ws] = 1'b1;
        m_tag[m_vic][ws] = tag_of(write_addr_ff);
        m_lru[ws]        = !m_vic;
      end
    end
    if (!idle) m_busy_left--;
    else if (inval_ff) model_clear();
    pend_valid = new_pend;
    pend_set   = fs;
    pend_way   = new_way;
  endtask

  task automatic check_busy();
    vectors++;
    if (busy !== (m_busy_left > 0)) begin
      miscompares++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_busy_left > 0);
    end
  endtask

  task automatic step(input bit f, input logic [31:0] fa, input bit w, input logic [31:0] wa,
                      input logic [63:0] wdat, input bit inv);
    fetch_ff      = f;
    fetch_addr_ff = fa;
    write_ff      = w;
    write_addr_ff = wa;
    write_data_ff = wdat;
    inval_ff      = inv;
    model_step();
    @(posedge clk);
    #1;
    check_busy();
    fetch_ff = 1'b0;
    write_ff = 1'b0;
    inval_ff = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    fetch_ff = 1'b0;
    write_ff = 1'b0;
    inval_ff = 1'b0;
    model_clear();
    m_vic      = 1'b0;
    pend_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    check_busy();
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, a, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic beat(input logic [31:0] a, input logic [63:0] d);
    step(1'b0, '0, 1'b1, a, d, 1'b0);
  endtask
  task automatic idle_until_ready();
    for (int i = 0; i < 2 * SETS && m_busy_left > 0; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic fill(input logic [31:0] base, input logic [63:0] d0, input logic [63:0] d1);
    beat(base, d0);
    beat(base + 8, d1);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(1, 3) * LB * SETS + $urandom_range(4, 5) * LB
               + $urandom_range(0, WORDS - 1) * 8);
  endfunction

  // Monitor: pops one expectation per presented response, flags overdue ones.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL no_response addr=%h issued_cyc=%0d got=none want=response", e.addr, e.cyc);
    end
    if (ic_hit_if || ic_miss_if) begin
      vectors++;
      if (ic_hit_if && ic_miss_if) begin
        miscompares++;
        $display("FAIL hit_and_miss cyc=%0d got=both want=one", cyc);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious cyc=%0d got=hit%b/miss%b want=none", cyc, ic_hit_if, ic_miss_if);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc + 1) begin
          miscompares++;
          $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc + 1);
        end
        if (ic_hit_if !== e.hit) begin
          miscompares++;
          $display("FAIL hit addr=%h got=%b want=%b", e.addr, ic_hit_if, e.hit);
        end else if (e.hit && ic_data_if !== e.data) begin
          miscompares++;
          $display("FAIL data addr=%h got=%h want=%h", e.addr, ic_data_if, e.data);
        end
        if (ic_addr_if !== e.addr) begin
          miscompares++;
          $display("FAIL addr got=%h want=%h", ic_addr_if, e.addr);
        end
      end
    end
  end

  initial begin
    do_reset(3);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    fetch(32'h1000);
    idle_until_ready();
    fill(32'h1040, 64'hAAAA_AAAA_0000_0001, 64'hBBBB_BBBB_0000_0002);
    fetch(32'h1044);
    fetch(32'h104C);
    fill(32'h2040, 64'h2222_0000_0000_0000, 64'h2222_0000_0000_0008);
    fetch(32'h1040);
    fill(32'h3040, 64'h3333_0000_0000_0000, 64'h3333_0000_0000_0008);
    fetch(32'h2040);
    fetch(32'h1040);
    fetch(32'h3040);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle_until_ready();
    fetch(32'h1040);
    beat(32'h5000, 64'h5555);
    fetch(32'h5000);
    fill(32'h6000, 64'h6666, 64'h6667);
    step(1'b1, 32'h6000, 1'b1, 32'h7000, 64'h7777, 1'b0);
    step(1'b1, 32'h6008, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 32'h1040, 64'h1111, 1'b1);
    idle_until_ready();
    beat(32'h1040, 64'h1234);
    do_reset(2);
    idle_until_ready();
    fetch(32'h1040);
    fill(32'h1040, 64'hC0, 64'hC8);
    fill(32'h2040, 64'hD0, 64'hD8);
    fetch(32'h1040);
    fetch(32'h2048);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        if ($urandom_range(0, 19) == 0)
          step(1'b1, rand_addr(), 1'b1, rand_addr(), {$urandom, $urandom}, 1'b0);
        else fetch(rand_addr());
      end else if (r < 85) begin
        logic [31:0] base;
        int          nb;
        base = rand_addr() & ~32'(LB - 1);
        nb   = ($urandom_range(0, 9) == 0) ? 1 : WORDS;
        for (int b = 0; b < nb; b++) begin
          beat(base + 32'(b * 8), {$urandom, $urandom});
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            if ($urandom_range(0, 1) == 1) fetch(rand_addr());
            else step(1'b0, '0, 1'b0, '0, '0, 1'b0);
          end
        end
      end else if (r < 88) begin
        step($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 1) == 1, rand_addr(),
             {$urandom, $urandom}, 1'b1);
      end else if (r < 89) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL leftover addr=%h got=none want=response", e.addr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
